// File: rtl/serial_alu_sequencer_if.sv
// Operation bus for serial_alu_sequencer. The requester drives the master
// modport and the sequencer takes the slave modport. The sequencer is
// parameterised with the same WIDTH as the interface instance.
interface serial_alu_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [1:0]       op;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;
  logic             error;
  logic             overflow;

  modport master (
    output start, op, sub, a, b,
    input  busy, done, result, carry_out, zero, error, overflow
  );

  modport slave (
    input  start, op, sub, a, b,
    output busy, done, result, carry_out, zero, error, overflow
  );
endinterface

// File: rtl/serial_alu_sequencer.sv
// Serial ALU sequencer: drives an external 1-bit ALU one bit at a time
// (reset, hold, sample) and assembles the WIDTH-bit result LSB first.
// Optional feature: define SEQ_OVERFLOW_EN to generate signed overflow for
// the add operation; otherwise the overflow output is tied to 0.
module serial_alu_sequencer #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_alu_sequencer_if.slave bus,
  output logic                  alu_reset,
  output logic                  alu_op1,
  output logic                  alu_op0,
  output logic                  alu_a,
  output logic                  alu_b,
  output logic                  alu_binv,
  output logic                  alu_cin,
  input  logic                  alu_y1,
  input  logic                  alu_y0,
  input  logic                  alu_error
);

  localparam int                IDX_W       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(WIDTH - 1);
  localparam logic [5:0]        HOLD_RELOAD = 6'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CLR, HOLD, SAMPLE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_lat_q, a_lat_d;
  logic [WIDTH-1:0] b_lat_q, b_lat_d;
  logic [1:0]       op_lat_q, op_lat_d;
  logic             sub_lat_q, sub_lat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             zero_q, zero_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             alu_reset_q, alu_reset_d;
  logic             alu_op1_q, alu_op1_d;
  logic             alu_op0_q, alu_op0_d;
  logic             alu_a_q, alu_a_d;
  logic             alu_b_q, alu_b_d;
  logic             alu_binv_q, alu_binv_d;
  logic             alu_cin_q, alu_cin_d;
`ifdef SEQ_OVERFLOW_EN
  logic             overflow_q, overflow_d;
`endif

  // Next-state logic; ALU drive is derived from next-state values so every output is a flop.
  always_comb begin
    state_d     = state_q;
    a_lat_d     = a_lat_q;
    b_lat_d     = b_lat_q;
    op_lat_d    = op_lat_q;
    sub_lat_d   = sub_lat_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    error_d     = error_q;
    done_d      = 1'b0;
`ifdef SEQ_OVERFLOW_EN
    overflow_d  = overflow_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_lat_d     = bus.a;
          b_lat_d     = bus.b;
          op_lat_d    = bus.op;
          sub_lat_d   = bus.sub;
          idx_d       = '0;
          carry_d     = 1'b0;
          result_d    = '0;
          carry_out_d = 1'b0;
          zero_d      = 1'b0;
          error_d     = 1'b0;
`ifdef SEQ_OVERFLOW_EN
          overflow_d  = 1'b0;
`endif
          state_d     = CLR;
        end
      end
      CLR: begin
        cnt_d   = HOLD_RELOAD;
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == 6'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 6'd1;
      end
      SAMPLE: begin
        result_d[idx_q] = alu_y0;
        carry_d         = alu_y1;
        error_d         = error_q | alu_error;
        if (idx_q == LAST_IDX) begin
          carry_out_d = alu_y1;
`ifdef SEQ_OVERFLOW_EN
          // carry_q still holds the carry into the MSB at this point
          overflow_d  = (op_lat_q == 2'b10) & (carry_q ^ alu_y1);
`endif
          state_d     = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = CLR;
        end
      end
      DONE: begin
        // done is registered out of DONE, so it coincides with the first IDLE cycle
        done_d  = 1'b1;
        zero_d  = (result_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == CLR) || (state_d == HOLD) || (state_d == SAMPLE);
    alu_reset_d = (state_d == IDLE) || (state_d == CLR) || (state_d == DONE);
    alu_op1_d   = 1'b0;
    alu_op0_d   = 1'b0;
    alu_a_d     = 1'b0;
    alu_b_d     = 1'b0;
    alu_binv_d  = 1'b0;
    alu_cin_d   = 1'b0;
    if (state_d != IDLE) begin
      alu_op1_d  = op_lat_d[1];
      alu_op0_d  = op_lat_d[0];
      alu_a_d    = a_lat_d[idx_d];
      alu_b_d    = b_lat_d[idx_d];
      alu_binv_d = sub_lat_d;
      alu_cin_d  = (idx_d == '0) ? sub_lat_d : carry_d;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_lat_q     <= '0;
      b_lat_q     <= '0;
      op_lat_q    <= '0;
      sub_lat_q   <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      alu_reset_q <= 1'b1;
      alu_op1_q   <= 1'b0;
      alu_op0_q   <= 1'b0;
      alu_a_q     <= 1'b0;
      alu_b_q     <= 1'b0;
      alu_binv_q  <= 1'b0;
      alu_cin_q   <= 1'b0;
`ifdef SEQ_OVERFLOW_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_lat_q     <= a_lat_d;
      b_lat_q     <= b_lat_d;
      op_lat_q    <= op_lat_d;
      sub_lat_q   <= sub_lat_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      alu_reset_q <= alu_reset_d;
      alu_op1_q   <= alu_op1_d;
      alu_op0_q   <= alu_op0_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_binv_q  <= alu_binv_d;
      alu_cin_q   <= alu_cin_d;
`ifdef SEQ_OVERFLOW_EN
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.zero      = zero_q;
  assign bus.error     = error_q;
`ifdef SEQ_OVERFLOW_EN
  assign bus.overflow  = overflow_q;
`else
  assign bus.overflow  = 1'b0;
`endif

  assign alu_reset = alu_reset_q;
  assign alu_op1   = alu_op1_q;
  assign alu_op0   = alu_op0_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_binv  = alu_binv_q;
  assign alu_cin   = alu_cin_q;

endmodule

// File: doc/serial_alu_sequencer.md
SERIAL_ALU_SEQUENCER -- requirements
Module: serial_alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 4: operand/result width in bits; legal 2..16.
REQ-002 Parameter HOLD_CYCLES, default 6: clocks each bit's inputs are held on the 1-bit ALU before sampling; legal 1..63.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous reset, active-low (reset=0 resets on the next rising clk edge).
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 op  input  2  operation select, passed unchanged to the 1-bit ALU as {alu_op1, alu_op0}.
REQ-007 sub  input  1  invert B and force carry-in of bit 0 to 1.
REQ-008 a, b  input  WIDTH each  operands, latched on accepted start.
REQ-009 busy  output  1  operation in progress.
REQ-010 done  output  1  one-cycle pulse; result, carry_out, zero and error are valid from this cycle until the next accepted start.
REQ-011 result  output  WIDTH  assembled result; carry_out  output  1  alu_y1 of MSB; zero  output  1  result==0; error  output  1  sticky OR of alu_error over all bits.
REQ-012 overflow  output  1  signed overflow (see Configuration).
REQ-013 alu_reset  output  1  active-high reset to the 1-bit ALU; alu_op1, alu_op0, alu_a, alu_b, alu_binv, alu_cin  output  1 each  ALU operand drive.
REQ-014 alu_y1, alu_y0, alu_error  input  1 each  ALU carry/secondary result, result bit, error flag.

Function
REQ-015 FSM states: IDLE, CLR, HOLD, SAMPLE, DONE.
REQ-016 IDLE: alu_reset=1, busy=0; start=1 -> latch a, b, op, sub; bit index=0; go to CLR.
REQ-017 CLR: exactly 1 cycle, alu_reset=1, busy=1; go to HOLD.
REQ-018 HOLD: alu_reset=0 for exactly HOLD_CYCLES cycles, counter reloaded on entry; go to SAMPLE.
REQ-019 SAMPLE: 1 cycle, alu_reset=0; capture result[i]=alu_y0, carry register=alu_y1, error|=alu_error; if i==WIDTH-1 go to DONE, else i=i+1 and go to CLR.
REQ-020 DONE: 1 cycle, done=1, busy=0; go to IDLE.
REQ-021 Outside IDLE, ALU drive: alu_a=a_lat[i], alu_b=b_lat[i], alu_binv=sub_lat, {alu_op1,alu_op0}=op_lat, alu_cin=sub_lat when i==0, otherwise the carry register captured at bit i-1.
REQ-022 Latency: done asserted exactly WIDTH*(HOLD_CYCLES+2)+1 cycles after the edge that accepts start.
REQ-023 start while busy or in DONE is ignored; no queuing.
REQ-024 Latched operands are immune to a/b/op/sub changes after acceptance.
REQ-025 zero is computed from the final result at DONE; error is cleared on each accepted start.
REQ-026 start asserted in the cycle after DONE is accepted normally (back-to-back operations).

Reset
REQ-027 While reset=0 at a clock edge: state=IDLE, busy=0, done=0, result=0, carry_out=0, zero=0, error=0, overflow=0, bit index=0, alu_reset=1, all other alu_* outputs=0.
REQ-028 Reset mid-operation aborts it with no done pulse; partial result is discarded.

Configuration
REQ-029 Macro SEQ_OVERFLOW_EN defined: at DONE, overflow = (carry into MSB) XOR carry_out when op==2'b10; otherwise overflow=0.
REQ-030 SEQ_OVERFLOW_EN undefined: overflow port present and tied to 0; no overflow logic synthesized.

Verification (WIDTH=4, HOLD_CYCLES=6; 1-bit ALU op 2'b10 = add with Binv/Cin)
REQ-031 reset=0 for 2 cycles, then reset=1 -> all outputs at REQ-027 values, alu_reset=1 in IDLE.
REQ-032 add a=0011, b=0101, sub=0 -> done exactly 33 cycles after start, result=1000, carry_out=0, zero=0, overflow=1 (with macro).
REQ-033 sub a=0101, b=0101, sub=1 -> result=0000, zero=1, carry_out=1, overflow=0.
REQ-034 start held high throughout an operation -> one done per 34 cycles, no extra operations; second operation accepted the cycle after DONE.
REQ-035 reset=0 during bit 2 HOLD -> IDLE next edge, no done, result=0; following start completes normally.
REQ-036 ALU model asserting alu_error on bit 1 only -> error=1 at done; cleared on next accepted start.
